and4_exerciser: RTL and testbench



---
 rtl/and4_exerciser_pkg.sv | 29 ++
 rtl/and4_ex_timer.sv | 39 +++
 rtl/and4_exerciser.sv | 155 +++++++++++++++
 tb/tb_and4_exerciser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/and4_exerciser_pkg.sv
// and4_exerciser_pkg: shared widths, state encoding and the golden model
// for the 4-input AND exerciser.
package and4_exerciser_pkg;

    localparam int VEC_W = 4;
    localparam int ERR_W = 8;

    // Raw state codes, also visible on the debug state port.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETTLE = SETTLE,
        ST_CHECK  = CHECK,
        ST_DONE   = DONE
    } state_e;

    localparam logic [VEC_W-1:0] VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Golden response of an ideal 4-input AND gate.
    function automatic logic and4_ref(input logic [VEC_W-1:0] vec);
        return &vec;
    endfunction

endpackage

// File: rtl/and4_ex_timer.sv
// and4_ex_timer: settle counter. load_i clears the count, en_i advances it,
// expire_o flags the last settle cycle (count == SETTLE_CYCLES-1).
module and4_ex_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/and4_exerciser.sv
// and4_exerciser: walks all 16 input vectors of a 4-input AND gate LOOPS
// times, holds each for SETTLE_CYCLES, samples dut_out in one CHECK cycle
// and accumulates mismatch count, first failing vector and pass flag.
// Optional macro AND4_EXERCISER_STOP_ON_FAIL_EN: end the run at the first
// mismatch, leaving the failing vector on drv_vec through DONE.
// Handshake: start is a level request honoured only in IDLE; busy is high
// from the cycle after acceptance until DONE; done pulses for one cycle
// with pass/err_cnt/first_fail_vec already final in that cycle.
module and4_exerciser
    import and4_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_out,
    output logic [VEC_W-1:0] drv_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic [1:0]       dbg_state
);

    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] ff_q, ff_d;

    logic             expire;
    logic             mismatch;
    logic             stop_hit;
    logic [ERR_W-1:0] err_chk;

    // Settle timer runs only in SETTLE and is re-armed everywhere else.
    and4_ex_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q != ST_SETTLE),
        .en_i    ((state_q == ST_SETTLE) && !expire),
        .expire_o(expire)
    );

    // Next-state and result logic; every register holds unless updated.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        loop_d   = loop_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_d     = ff_q;
        mismatch = (dut_out != and4_ref(vec_q));
        err_chk  = err_q;
        stop_hit = 1'b0;

        if (mismatch) begin
            err_chk = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
        end
`ifdef AND4_EXERCISER_STOP_ON_FAIL_EN
        stop_hit = mismatch;
`endif

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    loop_d  = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (expire) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                err_d = err_chk;
                if (mismatch && (err_q == '0)) begin
                    ff_d = vec_q;
                end
                if (!stop_hit && (vec_q != VEC_LAST)) begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = ST_SETTLE;
                end else if (!stop_hit && (loop_q < LOOP_LAST)) begin
                    loop_d  = loop_q + LW'(1);
                    vec_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_chk == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            loop_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign drv_vec        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail_vec = ff_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_and4_exerciser.sv
// tb_and4_exerciser: three exerciser instances (SETTLE/LOOPS = 1/1, 3/2,
// 1/18) each facing a table-driven gate model whose output lags drv_vec by
// SETTLE_CYCLES flops, so a too-early sample reads the previous vector.
module tb_and4_exerciser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_s [3];
    logic        dut_out_s [3];
    logic [3:0]  drv_w [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        pass_w [3];
    logic [7:0]  err_w [3];
    logic [3:0]  ff_w [3];
    logic [1:0]  st_w [3];
    logic [15:0] tbl [3];
    int          s_of [3] = '{1, 3, 1};
    int          l_of [3] = '{1, 2, 18};

    int n_tests = 0;
    int n_fail  = 0;

    and4_exerciser #(.SETTLE_CYCLES(1), .LOOPS(1)) u_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .dut_out(dut_out_s[0]),
        .drv_vec(drv_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_cnt(err_w[0]), .first_fail_vec(ff_w[0]), .dbg_state(st_w[0]));

    and4_exerciser #(.SETTLE_CYCLES(3), .LOOPS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .dut_out(dut_out_s[1]),
        .drv_vec(drv_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_cnt(err_w[1]), .first_fail_vec(ff_w[1]), .dbg_state(st_w[1]));

    and4_exerciser #(.SETTLE_CYCLES(1), .LOOPS(18)) u_c (
        .clk(clk), .rst(rst), .start(start_s[2]), .dut_out(dut_out_s[2]),
        .drv_vec(drv_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_cnt(err_w[2]), .first_fail_vec(ff_w[2]), .dbg_state(st_w[2]));

    // Gate models: truth table lookup delayed by SETTLE_CYCLES flops.
    logic       dly_a = 1'b0;
    logic [2:0] dly_b = 3'b000;
    logic       dly_c = 1'b0;
    always @(posedge clk) begin
        dly_a <= tbl[0][drv_w[0]];
        dly_b <= {dly_b[1:0], tbl[1][drv_w[1]]};
        dly_c <= tbl[2][drv_w[2]];
    end
    assign dut_out_s[0] = dly_a;
    assign dut_out_s[1] = dly_b[2];
    assign dut_out_s[2] = dly_c;

    // Reference: enumerate every vector the run should visit.
    function automatic void model(input logic [15:0] t, input int s, input int l,
                                  output int len, output int errs, output logic [3:0] ff,
                                  output logic [3:0] last_vec, output int wraps);
        bit stop;
        int idx;
        stop = 1'b0;
`ifdef AND4_EXERCISER_STOP_ON_FAIL_EN
        stop = 1'b1;
`endif
        errs = 0; ff = 4'h0; idx = 0;
        len = 16 * l * (s + 1);
        last_vec = 4'hF;
        wraps = l - 1;
        for (int lp = 0; lp < l; lp++) begin
            for (int v = 0; v < 16; v++) begin
                idx++;
                if (t[v] != (v == 15)) begin
                    if (errs == 0) ff = 4'(v);
                    if (errs < 255) errs++;
                    if (stop) begin
                        len = idx * (s + 1);
                        last_vec = 4'(v);
                        wraps = lp;
                        return;
                    end
                end
            end
        end
    endfunction

    task automatic kick(input int w, input bit hold);
        @(negedge clk);
        start_s[w] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_s[w] = 1'b0;
    endtask

    // Counts edges from the accepting edge until done and checks results.
    task automatic wait_and_check(input int w, input string name, input bit hold, input int repulse);
        int len, errs, wraps_exp, seen, wraps, busy_gaps;
        logic [3:0] ff_exp, last_exp, prev;
        model(tbl[w], s_of[w], l_of[w], len, errs, ff_exp, last_exp, wraps_exp);
        seen = 0; wraps = 0; busy_gaps = 0; prev = drv_w[w];
        for (int n = 1; n <= 3000; n++) begin
            if (repulse != 0 && n == repulse) start_s[w] = 1'b1;
            else if (!hold) start_s[w] = 1'b0;
            @(posedge clk);
            #1;
            if (done_w[w]) begin
                seen = n;
                break;
            end
            if (!busy_w[w]) busy_gaps++;
            if (prev == 4'hF && drv_w[w] == 4'h0) wraps++;
            prev = drv_w[w];
        end
        start_s[w] = hold;
        n_tests++;
        if (seen != len) begin
            n_fail++;
            $display("FAIL %s run_length: got %0d want %0d (0 = timeout)", name, seen, len);
            return;
        end
        n_tests++;
        if (err_w[w] !== 8'(errs)) begin
            n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_w[w], errs);
        end
        n_tests++;
        if (ff_w[w] !== ff_exp) begin
            n_fail++; $display("FAIL %s first_fail_vec: got %h want %h", name, ff_w[w], ff_exp);
        end
        n_tests++;
        if (pass_w[w] !== (errs == 0)) begin
            n_fail++; $display("FAIL %s pass: got %b want %b", name, pass_w[w], errs == 0);
        end
        n_tests++;
        if (drv_w[w] !== last_exp) begin
            n_fail++; $display("FAIL %s drv_vec_at_done: got %h want %h", name, drv_w[w], last_exp);
        end
        n_tests++;
        if (wraps != wraps_exp || busy_gaps != 0 || busy_w[w] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wraps/busy: got wraps=%0d gaps=%0d busy@done=%b want %0d/0/0",
                     name, wraps, busy_gaps, busy_w[w], wraps_exp);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done_w[w] !== 1'b0 || busy_w[w] !== 1'b0) begin
            n_fail++; $display("FAIL %s after_done: got done=%b busy=%b want 0/0", name, done_w[w], busy_w[w]);
        end
        if (hold) begin
            @(posedge clk);
            #1;
            start_s[w] = 1'b0;
            n_tests++;
            if (busy_w[w] !== 1'b1) begin
                n_fail++; $display("FAIL %s held_restart busy: got %b want 1", name, busy_w[w]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            n_tests++;
            if ({drv_w[w], busy_w[w], done_w[w], pass_w[w], err_w[w], ff_w[w], st_w[w]} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got drv=%h busy=%b done=%b pass=%b err=%0d ff=%h st=%0d want all 0",
                         w, drv_w[w], busy_w[w], done_w[w], pass_w[w], err_w[w], ff_w[w], st_w[w]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        tbl[0] = 16'h8000; kick(0, 1'b0); wait_and_check(0, "ideal_and", 1'b0, 0);
        tbl[0] = 16'h0000; kick(0, 1'b0); wait_and_check(0, "stuck0", 1'b0, 0);
        tbl[0] = 16'hFFFF; kick(0, 1'b0); wait_and_check(0, "stuck1", 1'b0, 0);
        tbl[1] = 16'hFFFE; kick(1, 1'b0); wait_and_check(1, "or_gate_loops", 1'b0, 0);
        tbl[2] = 16'hFFFF; kick(2, 1'b0); wait_and_check(2, "err_saturate", 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        tbl[0] = 16'h8000;
        kick(0, 1'b0); wait_and_check(0, "repulse_busy", 1'b0, 5);
        kick(0, 1'b1); wait_and_check(0, "held_first", 1'b1, 0);
        wait_and_check(0, "held_second", 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int w;
            w = i % 3;
            tbl[w] = 16'($urandom_range(0, 16'hFFFF));
            kick(w, 1'b0);
            wait_and_check(w, $sformatf("random%0d_tbl%h", i, tbl[w]), 1'b0, 0);
        end
    endtask

    task automatic test_reset_mid_run();
        int hits;
        bit found;
        tbl[0] = 16'h8000;
        kick(0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (drv_w[0] == 4'h7) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL midrun_reach7: got drv=%h want 7", drv_w[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({drv_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ff_w[0], st_w[0]} !== 21'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got drv=%h busy=%b done=%b pass=%b err=%0d ff=%h st=%0d want all 0",
                     drv_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ff_w[0], st_w[0]);
        end
        rst = 1'b0;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_w[0]) hits++;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++; $display("FAIL midrun_no_done: got %0d done pulses want 0", hits);
        end
    endtask

    initial begin
        for (int w = 0; w < 3; w++) begin
            start_s[w] = 1'b0;
            tbl[w] = 16'h8000;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
